// File: rtl/aib_sram_pkg.sv
// rtl/aib_sram_pkg.sv - shared types and read latency for aib_sram_ctrl (AIB_SRAM_OUTREG_EN selects L=2)
package aib_sram_pkg;

    typedef enum logic [1:0] {
        A_IDLE,
        A_REQ,
        A_RD,
        A_RESP
    } apb_state_e;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_BUS,
        SRC_APB
    } src_e;

`ifdef AIB_SRAM_OUTREG_EN
    localparam int RD_LAT = 2;
`else
    localparam int RD_LAT = 1;
`endif

endpackage

// File: rtl/aib_sram_macro.sv
// rtl/aib_sram_macro.sv - single-port SRAM macro wrapper with active-low pins and behavioural array
module aib_sram_macro #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4096,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              cen,
    input  logic              gwen,
    input  logic [DATA_W-1:0] wen,
    input  logic [ADDR_W-1:0] a,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q,
    input  logic              stov,
    input  logic [2:0]        ema,
    input  logic [1:0]        emaw,
    input  logic              emas,
    input  logic              ret1n
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Margin pins only matter to the silicon; the model ignores them.
    logic unused_margin;
    assign unused_margin = ^{stov, ema, emaw, emas};

    always_ff @(posedge clk) begin
        if (!cen && ret1n) begin
            if (!gwen) begin
                mem[a] <= (mem[a] & wen) | (d & ~wen);
            end else begin
                q <= mem[a];
            end
        end
    end

endmodule

// File: rtl/aib_sram_ctrl.sv
// rtl/aib_sram_ctrl.sv - bus/APB arbiter onto one SRAM macro; AIB_SRAM_OUTREG_EN adds a Q register stage
module aib_sram_ctrl
    import aib_sram_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 4096,
    parameter int STARVE_MAX = 4,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_mem_valid,
    output logic              o_mem_ready,
    input  logic              i_mem_write,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic [DATA_W-1:0] i_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_wmask,
    output logic              o_mem_rvalid,
    output logic [DATA_W-1:0] o_mem_rdata,
    input  logic              i_psel,
    input  logic              i_penable,
    input  logic              i_pwrite,
    input  logic [31:0]       i_paddr,
    input  logic [DATA_W-1:0] i_pwdata,
    output logic              o_pready,
    output logic              o_pslverr,
    output logic [DATA_W-1:0] o_prdata
);

    apb_state_e        state, state_nxt;
    logic [3:0]        starve_cnt;
    logic              apb_access, addr_ok, apb_force;
    logic              bus_grant, apb_grant, apb_rd_arrive;
    logic [ADDR_W-1:0] apb_addr;
    logic              apb_write;
    logic [DATA_W-1:0] apb_wdata;
    src_e              lat_pipe [RD_LAT];

    logic              sram_cen, sram_gwen;
    logic [DATA_W-1:0] sram_wen, sram_d, sram_q, rd_data;
    logic [ADDR_W-1:0] sram_a;

    logic unused_paddr;
    assign unused_paddr = ^i_paddr[1:0];

    assign apb_access = i_psel & i_penable;
    assign addr_ok    = (i_paddr[31:ADDR_W+2] == '0);
    assign apb_force  = (state == A_REQ) && (starve_cnt == 4'(STARVE_MAX));

    // Ready is held low while in reset so nothing reaches the macro then.
    assign o_mem_ready = i_rst_n & ~apb_force;
    assign bus_grant   = i_mem_valid & o_mem_ready;

    assign apb_rd_arrive = (lat_pipe[RD_LAT-1] == SRC_APB);
    assign o_mem_rvalid  = (lat_pipe[RD_LAT-1] == SRC_BUS);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= A_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            A_IDLE:  if (apb_access) state_nxt = addr_ok ? A_REQ : A_RESP;
            A_REQ:   if (apb_grant) state_nxt = apb_write ? A_RESP : A_RD;
            A_RD:    if (apb_rd_arrive) state_nxt = A_RESP;
            A_RESP:  state_nxt = A_IDLE;
            default: state_nxt = A_IDLE;
        endcase
    end

    always_comb begin
        o_pready  = (state == A_RESP);
        apb_grant = (state == A_REQ) && (!i_mem_valid || apb_force);
        sram_cen  = ~(bus_grant | apb_grant);
        if (bus_grant) begin
            sram_gwen = ~i_mem_write;
            sram_wen  = ~i_mem_wmask;
            sram_a    = i_mem_addr;
            sram_d    = i_mem_wdata;
        end else begin
            sram_gwen = ~apb_write;
            sram_wen  = '0;
            sram_a    = apb_addr;
            sram_d    = apb_wdata;
        end
    end

    // Tags follow each read through the macro so the returning word finds its owner.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < RD_LAT; i++) lat_pipe[i] <= SRC_NONE;
        end else begin
            lat_pipe[0] <= (bus_grant && !i_mem_write) ? SRC_BUS :
                           (apb_grant && !apb_write)   ? SRC_APB : SRC_NONE;
            for (int i = 1; i < RD_LAT; i++) lat_pipe[i] <= lat_pipe[i-1];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            starve_cnt <= '0;
            apb_addr   <= '0;
            apb_write  <= 1'b0;
            apb_wdata  <= '0;
            o_prdata   <= '0;
            o_pslverr  <= 1'b0;
        end else begin
            if (state != A_REQ || apb_grant) begin
                starve_cnt <= '0;
            end else if (bus_grant && starve_cnt != 4'(STARVE_MAX)) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
            if (state == A_IDLE && apb_access) begin
                apb_addr  <= i_paddr[ADDR_W+1:2];
                apb_write <= i_pwrite;
                apb_wdata <= i_pwdata;
            end
            // Only the IDLE->RESP shortcut is an error response.
            if (state != A_RESP && state_nxt == A_RESP) begin
                o_pslverr <= (state == A_IDLE);
            end
            if (state == A_RD && apb_rd_arrive) begin
                o_prdata <= rd_data;
            end
        end
    end

    aib_sram_macro #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_macro (
        .clk   (i_clk),
        .cen   (sram_cen),
        .gwen  (sram_gwen),
        .wen   (sram_wen),
        .a     (sram_a),
        .d     (sram_d),
        .q     (sram_q),
        .stov  (1'b0),
        .ema   (3'd2),
        .emaw  (2'd1),
        .emas  (1'b0),
        .ret1n (1'b1)
    );

`ifdef AIB_SRAM_OUTREG_EN
    logic [DATA_W-1:0] q_reg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            q_reg <= '0;
        end else begin
            q_reg <= sram_q;
        end
    end

    assign rd_data = q_reg;
`else
    assign rd_data = sram_q;
`endif

    assign o_mem_rdata = rd_data;

endmodule

// File: tb/tb_aib_sram_ctrl.sv
// tb/tb_aib_sram_ctrl.sv - self-checking bench for aib_sram_ctrl
module tb_aib_sram_ctrl;
    import aib_sram_pkg::*;

    localparam int DATA_W     = 32;
    localparam int DEPTH      = 4096;
    localparam int ADDR_W     = $clog2(DEPTH);
    localparam int STARVE_MAX = 4;
    localparam int L          = RD_LAT;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
        int          cyc;
    } apb_vec_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              mem_valid, mem_ready, mem_write, rvalid;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] wdata, wmask, rdata;
    logic              psel, penable, pwrite, pready, pslverr;
    logic [31:0]       paddr;
    logic [DATA_W-1:0] pwdata, prdata;

    int total = 0;
    int bad = 0;
    int cen_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (!dut.sram_cen) cen_cnt <= cen_cnt + 1;

    aib_sram_ctrl #(
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_mem_valid  (mem_valid),
        .o_mem_ready  (mem_ready),
        .i_mem_write  (mem_write),
        .i_mem_addr   (mem_addr),
        .i_mem_wdata  (wdata),
        .i_mem_wmask  (wmask),
        .o_mem_rvalid (rvalid),
        .o_mem_rdata  (rdata),
        .i_psel       (psel),
        .i_penable    (penable),
        .i_pwrite     (pwrite),
        .i_paddr      (paddr),
        .i_pwdata     (pwdata),
        .o_pready     (pready),
        .o_pslverr    (pslverr),
        .o_prdata     (prdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic bus_drive(input logic v, input logic w, input logic [ADDR_W-1:0] a,
                             input logic [31:0] d, input logic [31:0] m);
        mem_valid = v;
        mem_write = w;
        mem_addr  = a;
        wdata     = d;
        wmask     = m;
    endtask

    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                            output int cyc, output logic [31:0] rd, output logic err);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
        @(negedge clk);
        penable = 1'b1;
        cyc = -1; rd = '0; err = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (pready) begin
                cyc = c; rd = prdata; err = pslverr;
                break;
            end
            @(negedge clk);
        end
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        check("pready_one_cycle", 32'(pready), 32'd0);
    endtask

    apb_vec_t    vec [10];
    logic [31:0] vals [8];
    int          cyc, c0;
    logic [31:0] rd;
    logic        err;

    initial begin
        bus_drive(0, 0, '0, '0, '0);
        psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;

        vec[0] = '{1'b1, 32'h0000_0040, 32'h1234_5678, 1'b0, 2};
        vec[1] = '{1'b0, 32'h0000_0040, 32'h1234_5678, 1'b0, L + 2};
        vec[2] = '{1'b1, 32'h0000_0044, 32'hA5A5_A5A5, 1'b0, 2};
        vec[3] = '{1'b0, 32'h0000_0044, 32'hA5A5_A5A5, 1'b0, L + 2};
        vec[4] = '{1'b0, 32'h0000_0042, 32'h1234_5678, 1'b0, L + 2};
        vec[5] = '{1'b0, 32'(4 * DEPTH), 32'h1234_5678, 1'b1, 1};
        vec[6] = '{1'b1, 32'h0000_3FFC, 32'hCAFE_F00D, 1'b0, 2};
        vec[7] = '{1'b0, 32'h0000_3FFC, 32'hCAFE_F00D, 1'b0, L + 2};
        vec[8] = '{1'b1, 32'hFFFF_FFFC, 32'hBAD0_BAD0, 1'b1, 1};
        vec[9] = '{1'b0, 32'h0000_3FFC, 32'hCAFE_F00D, 1'b0, L + 2};

        // reset values
        #12;
        check("rst_mem_ready", 32'(mem_ready), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_pready", 32'(pready), 32'd0);
        check("rst_pslverr", 32'(pslverr), 32'd0);
        check("rst_prdata", prdata, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_mem_ready", 32'(mem_ready), 32'd1);

        // masked bus write then read-back
        bus_drive(1, 1, ADDR_W'(5), 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        check("mask_wr1_ready", 32'(mem_ready), 32'd1);
        @(negedge clk);
        bus_drive(1, 1, ADDR_W'(5), 32'h0000_0000, 32'h0000_FFFF);
        check("mask_wr2_ready", 32'(mem_ready), 32'd1);
        @(negedge clk);
        bus_drive(1, 0, ADDR_W'(5), '0, '0);
        check("mask_rd_ready", 32'(mem_ready), 32'd1);
        for (int k = 1; k <= L + 1; k++) begin
            @(negedge clk);
            bus_drive(0, 0, '0, '0, '0);
            check($sformatf("mask_rvalid_%0d", k), 32'(rvalid), 32'(k == L));
            if (k == L) check("mask_rdata", rdata, 32'hDEAD_0000);
        end

        // back-to-back writes then reads of addr 0..7
        for (int i = 0; i < 8; i++) begin
            vals[i] = 32'hA000_0000 | (32'(i) * 32'h0001_1111);
            @(negedge clk);
            bus_drive(1, 1, ADDR_W'(i), vals[i], 32'hFFFF_FFFF);
        end
        for (int c = 0; c < 8 + L + 1; c++) begin
            @(negedge clk);
            if (c < 8) bus_drive(1, 0, ADDR_W'(c), '0, '0);
            else       bus_drive(0, 0, '0, '0, '0);
            check($sformatf("b2b_rvalid_%0d", c), 32'(rvalid), 32'(c >= L && c - L < 8));
            if (c >= L && c - L < 8) check($sformatf("b2b_rdata_%0d", c), rdata, vals[c - L]);
        end

        // APB vectors
        for (int i = 0; i < 10; i++) begin
            c0 = cen_cnt;
            apb_xfer(vec[i].wr, vec[i].addr, vec[i].data, cyc, rd, err);
            check($sformatf("apb%0d_latency", i), 32'(cyc), 32'(vec[i].cyc));
            check($sformatf("apb%0d_pslverr", i), 32'(err), 32'(vec[i].err));
            if (!vec[i].wr) check($sformatf("apb%0d_prdata", i), rd, vec[i].data);
            if (vec[i].err) check($sformatf("apb%0d_no_access", i), 32'(cen_cnt - c0), 32'd0);
        end

        // starvation guard: bus saturated during an APB read
        @(negedge clk);
        bus_drive(1, 0, ADDR_W'(1), '0, '0);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h40;
        for (int c = 0; c <= 12; c++) begin
            @(negedge clk);
            if (c == 0) penable = 1'b1;
            check($sformatf("starve_ready_%0d", c), 32'(mem_ready), 32'(c != 5));
            check($sformatf("starve_rvalid_%0d", c), 32'(rvalid), 32'((c - L >= -1) && (c - L != 5)));
            if ((c - L >= -1) && (c - L != 5)) check($sformatf("starve_rdata_%0d", c), rdata, vals[1]);
            check($sformatf("starve_pready_%0d", c), 32'(pready), 32'(c == 6 + L));
            if (c == 6 + L) begin
                check("starve_prdata", prdata, 32'h1234_5678);
                check("starve_pslverr", 32'(pslverr), 32'd0);
                psel = 1'b0; penable = 1'b0;
            end
        end
        bus_drive(0, 0, '0, '0, '0);

        // reset one cycle after an APB read grant
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h44;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        psel = 1'b0; penable = 1'b0;
        #1;
        check("midrst_pready", 32'(pready), 32'd0);
        check("midrst_rvalid", 32'(rvalid), 32'd0);
        check("midrst_mem_ready", 32'(mem_ready), 32'd0);
        check("midrst_prdata", prdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("postrst_pready_%0d", k), 32'(pready), 32'd0);
            check($sformatf("postrst_rvalid_%0d", k), 32'(rvalid), 32'd0);
        end
        apb_xfer(1'b0, 32'h44, '0, cyc, rd, err);
        check("postrst_apb_latency", 32'(cyc), 32'(L + 2));
        check("postrst_apb_prdata", rd, 32'hA5A5_A5A5);
        check("postrst_apb_pslverr", 32'(err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
